// File: rtl/msrv32_store_unit_pkg.sv
// Shared msrv32 store-path definitions: store size codes, FSM state
// encodings, the default bus-ack timeout and the alignment rule.
package msrv32_store_unit_pkg;

  // Store size codes carried on store_size_in; 2'b11 is treated as word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Cycles a write request may stay unacknowledged before a bus error.
  localparam int unsigned ACK_TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_ERR  = 2'b10
  } store_state_e;

  // Byte stores are always aligned; halves need addr[0]=0; words need
  // addr[1:0]=0 (both word codes).
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/msrv32_store_unit_lane.sv
// Store lane steering: replicates the right-justified store data across
// all byte lanes and builds the byte-enable mask from size and addr[1:0].
module msrv32_store_lane
  import msrv32_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2,
  output logic [31:0] data,
  output logic [3:0]  mask
);

  // Select replicated data and lane mask for the store size.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    data = rs2;
    mask = 4'b1111;
    case (size)
      SIZE_BYTE: begin
        data = {4{rs2[7:0]}};
        mask = 4'b0001 << addr;
      end
      SIZE_HALF: begin
        data = {2{rs2[15:0]}};
        mask = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        data = rs2;
        mask = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_store_unit.sv
// Store unit: accepts an aligned store from the pipeline, holds a write
// request to data memory until it is acknowledged, raises a bus error if
// the ack does not arrive within ACK_TIMEOUT cycles, and flags misaligned
// stores without touching memory.
module msrv32_store_unit
  import msrv32_store_unit_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_wr_req_in,
  input  logic [1:0]  store_size_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        ms_riscv32_mp_dmack_in,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        store_stall_out,
  output logic        misaligned_store_out,
  output logic        store_err_out
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  store_state_e state, next_state;
  logic [7:0]   wait_cnt;
  logic         aligned;
  logic         accept;
  logic         misaligned_hit;
  logic         timeout_hit;
  logic [31:0]  lane_data;
  logic [3:0]   lane_mask;
  logic [31:0]  addr_q;
  logic [31:0]  data_q;
  logic [3:0]   mask_q;
  logic         misaligned_q;

  msrv32_store_lane u_lane (
    .size (store_size_in),
    .addr (iadder_in[1:0]),
    .rs2  (rs2_in),
    .data (lane_data),
    .mask (lane_mask)
  );

  assign aligned        = !is_misaligned(store_size_in, iadder_in[1:0]);
  assign accept         = (state == ST_IDLE) && mem_wr_req_in && aligned;
  assign misaligned_hit = (state == ST_IDLE) && mem_wr_req_in && !aligned;
  assign timeout_hit    = (wait_cnt == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (ms_riscv32_mp_rst_in) state <= ST_IDLE;
    else                      state <= next_state;
  end

  // Next-state logic; an ack in the timeout cycle wins over the error.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_REQ;
      ST_REQ: begin
        if (ms_riscv32_mp_dmack_in) next_state = ST_IDLE;
        else if (timeout_hit)       next_state = ST_ERR;
      end
      ST_ERR:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Ack-wait counter: cleared on accept, counts unacknowledged REQ cycles.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in)
      wait_cnt <= '0;
    else if (accept)
      wait_cnt <= '0;
    else if (state == ST_REQ && !ms_riscv32_mp_dmack_in)
      wait_cnt <= wait_cnt + 8'd1;
  end

  // Capture address, lane data and mask when a store is accepted.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    // NOTE: the payload registers carry no reset; they are only visible
    // through the request gating below, which is 0 out of reset.
    if (accept) begin
      addr_q <= {iadder_in[31:2], 2'b00};
      data_q <= lane_data;
      mask_q <= lane_mask;
    end
  end

  // One-cycle misaligned-store pulse, the cycle after the offending store.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) misaligned_q <= 1'b0;
    else                      misaligned_q <= misaligned_hit;
  end

  // Outputs: payload only visible while requesting; stall blocked in reset.
  always_comb begin
    ms_riscv32_mp_dmwr_req_out  = (state == ST_REQ);
    ms_riscv32_mp_dmaddr_out    = ms_riscv32_mp_dmwr_req_out ? addr_q : 32'd0;
    ms_riscv32_mp_dmdata_out    = ms_riscv32_mp_dmwr_req_out ? data_q : 32'd0;
    ms_riscv32_mp_dmwr_mask_out = ms_riscv32_mp_dmwr_req_out ? mask_q : 4'd0;
    store_err_out               = (state == ST_ERR);
    misaligned_store_out        = misaligned_q;
    store_stall_out             = !ms_riscv32_mp_rst_in &&
                                  ((state != ST_IDLE) || accept);
  end

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Directed bench for msrv32_store_unit: a table of single stores with
// hand-computed lane data/masks and ack delays, plus sequences for the
// ack timeout, requests arriving mid-store and reset during a request.
module tb_msrv32_store_unit;
  import msrv32_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_wr_req;
  logic [1:0]  size;
  logic [31:0] iadder;
  logic [31:0] rs2;
  logic        ack;
  logic        req;
  logic [31:0] dmaddr;
  logic [31:0] dmdata;
  logic [3:0]  mask;
  logic        stall;
  logic        mis;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv32_store_unit #(.ACK_TIMEOUT(15)) dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst),
    .mem_wr_req_in               (mem_wr_req),
    .store_size_in               (size),
    .iadder_in                   (iadder),
    .rs2_in                      (rs2),
    .ms_riscv32_mp_dmack_in      (ack),
    .ms_riscv32_mp_dmwr_req_out  (req),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmdata_out    (dmdata),
    .ms_riscv32_mp_dmwr_mask_out (mask),
    .store_stall_out             (stall),
    .misaligned_store_out        (mis),
    .store_err_out               (err)
  );

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] rs2;
    int          waits;     // REQ cycles before the ack cycle
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"},   32'(req),    32'd0);
    check({tag, "_addr"},  dmaddr,      32'd0);
    check({tag, "_data"},  dmdata,      32'd0);
    check({tag, "_mask"},  32'(mask),   32'd0);
    check({tag, "_stall"}, 32'(stall),  32'd0);
    check({tag, "_err"},   32'(err),    32'd0);
  endtask

  // Present one store for a single cycle, then follow it to completion.
  task automatic run_store(input vec_t v, input string tag);
    @(negedge clk);
    mem_wr_req = 1'b1; size = v.size; iadder = v.addr; rs2 = v.rs2;
    #1;
    check({tag, "_stall_present"}, 32'(stall), 32'(!v.exp_mis));
    check({tag, "_req_present"},   32'(req),   32'd0);
    @(negedge clk);
    mem_wr_req = 1'b0; iadder = '0; rs2 = '0; size = '0;
    #1;
    if (v.exp_mis) begin
      check({tag, "_mis_pulse"}, 32'(mis),   32'd1);
      check({tag, "_mis_stall"}, 32'(stall), 32'd0);
      check({tag, "_mis_req"},   32'(req),   32'd0);
      @(negedge clk); #1;
      check({tag, "_mis_clear"}, 32'(mis),   32'd0);
      check({tag, "_mis_req2"},  32'(req),   32'd0);
    end else begin
      for (int i = 0; i <= v.waits; i++) begin
        check($sformatf("%s_c%0d_req", tag, i),   32'(req),   32'd1);
        check($sformatf("%s_c%0d_addr", tag, i),  dmaddr,     v.exp_addr);
        check($sformatf("%s_c%0d_data", tag, i),  dmdata,     v.exp_data);
        check($sformatf("%s_c%0d_mask", tag, i),  32'(mask),  32'(v.exp_mask));
        check($sformatf("%s_c%0d_stall", tag, i), 32'(stall), 32'd1);
        check($sformatf("%s_c%0d_err", tag, i),   32'(err),   32'd0);
        check($sformatf("%s_c%0d_mis", tag, i),   32'(mis),   32'd0);
        ack = (i == v.waits);
        @(negedge clk); #1;
      end
      ack = 1'b0;
      check_quiet({tag, "_done"});
      @(negedge clk); #1;
      check({tag, "_after_err"}, 32'(err), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    int   n;

    //          size       addr          rs2           w  mis  addr          data          mask
    vecs[0]  = '{SIZE_BYTE, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000};
    vecs[1]  = '{SIZE_HALF, 32'h0000_2002, 32'h1234_BEEF, 3, 0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
    vecs[2]  = '{SIZE_WORD, 32'h0000_3001, 32'h0BAD_0BAD, 0, 1, 32'h0,         32'h0,         4'b0000};
    vecs[3]  = '{SIZE_BYTE, 32'h0000_5000, 32'hDEAD_BE12, 1, 0, 32'h0000_5000, 32'h1212_1212, 4'b0001};
    vecs[4]  = '{SIZE_BYTE, 32'h0000_5005, 32'h0000_0034, 0, 0, 32'h0000_5004, 32'h3434_3434, 4'b0010};
    vecs[5]  = '{SIZE_BYTE, 32'h0000_5006, 32'hFFFF_FF56, 2, 0, 32'h0000_5004, 32'h5656_5656, 4'b0100};
    vecs[6]  = '{SIZE_HALF, 32'h0000_6000, 32'hCAFE_0123, 2, 0, 32'h0000_6000, 32'h0123_0123, 4'b0011};
    vecs[7]  = '{SIZE_HALF, 32'h0000_6001, 32'h1111_2222, 0, 1, 32'h0,         32'h0,         4'b0000};
    vecs[8]  = '{SIZE_HALF, 32'h0000_6003, 32'h3333_4444, 0, 1, 32'h0,         32'h0,         4'b0000};
    vecs[9]  = '{SIZE_WORD, 32'h0000_7004, 32'h89AB_CDEF, 0, 0, 32'h0000_7004, 32'h89AB_CDEF, 4'b1111};
    vecs[10] = '{2'b11,     32'h0000_7008, 32'h1357_2468, 14, 0, 32'h0000_7008, 32'h1357_2468, 4'b1111};
    vecs[11] = '{2'b11,     32'h0000_700A, 32'h5555_AAAA, 0, 1, 32'h0,         32'h0,         4'b0000};

    rst = 1'b1; mem_wr_req = 1'b0; size = '0; iadder = '0; rs2 = '0; ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset_mis", 32'(mis), 32'd0);
    rst = 1'b0;

    // Ack arriving while idle must not disturb anything.
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0; #1;
    check_quiet("idle_ack");

    for (int i = 0; i < 12; i++) run_store(vecs[i], $sformatf("v%0d", i));

    // Timeout: unacknowledged word store; a second store presented during
    // REQ must be ignored and must not alter the held request.
    @(negedge clk);
    mem_wr_req = 1'b1; size = SIZE_WORD; iadder = 32'h0000_4000; rs2 = 32'hFACE_B00C;
    @(negedge clk);
    size = SIZE_BYTE; iadder = 32'h0000_9999; rs2 = 32'h0000_0077;
    #1;
    n = 0;
    while (req && n < 40) begin
      check($sformatf("to_c%0d_addr", n), dmaddr, 32'h0000_4000);
      check($sformatf("to_c%0d_data", n), dmdata, 32'hFACE_B00C);
      n++;
      @(negedge clk);
      if (!req) mem_wr_req = 1'b0;
      #1;
    end
    mem_wr_req = 1'b0;
    check("to_req_cycles", 32'(n),     32'd15);
    check("to_err_pulse",  32'(err),   32'd1);
    check("to_err_req",    32'(req),   32'd0);
    check("to_err_mask",   32'(mask),  32'd0);
    @(negedge clk); #1;
    check("to_err_clear",  32'(err),   32'd0);
    check_quiet("to_idle");

    // Reset on the second REQ cycle drops the store without an error.
    @(negedge clk);
    mem_wr_req = 1'b1; size = SIZE_WORD; iadder = 32'h0000_8000; rs2 = 32'h1122_3344;
    @(negedge clk);
    mem_wr_req = 1'b0; #1;
    check("rst_req1", 32'(req), 32'd1);
    @(negedge clk); #1;
    check("rst_req2", 32'(req), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    check_quiet("rst_mid");
    rst = 1'b0;
    @(negedge clk); #1;
    check_quiet("rst_release");
    v = '{SIZE_HALF, 32'h0000_8002, 32'h0000_ABCD, 1, 0, 32'h0000_8000, 32'hABCD_ABCD, 4'b1100};
    run_store(v, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
